arp_decode_stream: RTL

ARP_DECODE_STREAM -- requirements
Module: arp_decode_stream

---
 rtl/arp_pkg.sv | 53 +++++
 rtl/arp_decode_stream_if.sv | 31 +++
 rtl/arp_byte_lane_writer.sv | 32 +++
 rtl/arp_decode_stream.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared ARP decode constants, FSM/error enumerations and helpers.
// Byte offsets count wire bytes from the first byte of the ARP payload.
package arp_pkg;

    localparam int ARP_LEN = 28;

    localparam int OFF_HTYPE = 0;
    localparam int OFF_PTYPE = 2;
    localparam int OFF_HLEN  = 4;
    localparam int OFF_PLEN  = 5;
    localparam int OFF_OPER  = 6;
    localparam int OFF_SHA   = 8;
    localparam int OFF_SPA   = 14;
    localparam int OFF_THA   = 18;
    localparam int OFF_TPA   = 24;

    localparam logic [15:0] HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  HLEN_ETH   = 8'd6;
    localparam logic [7:0]  PLEN_IPV4  = 8'd4;
    localparam logic [15:0] OPER_REQ   = 16'h0001;
    localparam logic [15:0] OPER_REP   = 16'h0002;

    typedef enum logic [1:0] {
        ERR_SHORT  = 2'd0,
        ERR_HEADER = 2'd1,
        ERR_ABORT  = 2'd2,
        ERR_TARGET = 2'd3
    } arp_err_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN
    } arp_state_e;

    function automatic int empty_width(input int dw);
        return (dw <= 16) ? 1 : $clog2(dw / 8);
    endfunction

    function automatic logic hdr_ok(
        input logic [15:0] ht,
        input logic [15:0] pt,
        input logic [7:0]  hl,
        input logic [7:0]  pl,
        input logic [15:0] op
    );
        return (ht == HTYPE_ETH) && (pt == PTYPE_IPV4) &&
               (hl == HLEN_ETH) && (pl == PLEN_IPV4) &&
               ((op == OPER_REQ) || (op == OPER_REP));
    endfunction

endpackage

// File: rtl/arp_decode_stream_if.sv
// Framed input stream carrying the ARP payload (MS byte first).
// master drives data_in/valid/sop/eop/empty, slave receives them.
interface arp_decode_stream_if
    import arp_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    localparam int EW = empty_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_sop;
    logic                  data_in_eop;
    logic [EW-1:0]         data_in_empty;

    modport master (
        output data_in,
        output data_in_valid,
        output data_in_sop,
        output data_in_eop,
        output data_in_empty
    );

    modport slave (
        input data_in,
        input data_in_valid,
        input data_in_sop,
        input data_in_eop,
        input data_in_empty
    );
endinterface

// File: rtl/arp_byte_lane_writer.sv
// Places the valid bytes of one input word into the 28-byte staging
// image at the current byte counter; in: stage_q/data/base/nbytes/en, out: stage_d.
module arp_byte_lane_writer
    import arp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CW         = 6
) (
    input  logic [ARP_LEN*8-1:0]  stage_q,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [CW-1:0]         base,
    input  logic [3:0]            nbytes,
    input  logic                  en,
    output logic [ARP_LEN*8-1:0]  stage_d
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int TOP = ARP_LEN * 8 - 1;

    // Wire byte p lives at bits [TOP-8p -: 8]; bytes past 27 fall off.
    always_comb begin
        stage_d = stage_q;
        for (int p = 0; p < ARP_LEN; p++) begin
            for (int k = 0; k < NB; k++) begin
                if (en && (k < int'(nbytes)) &&
                    (int'(base) + k == p)) begin
                    stage_d[TOP-8*p -: 8] =
                        data[DATA_WIDTH-1-8*k -: 8];
                end
            end
        end
    end
endmodule

// File: rtl/arp_decode_stream.sv
// ARP payload decoder: captures bytes 0..27 of a framed stream, checks the
// header and publishes fields with a decode_valid/decode_error pulse.
// Ports: clk, reset_n, rx (stream slave), local_ip, field outputs,
// decode_valid, decode_error, error_code.
// Build option: ARP_TARGET_FILTER_EN accepts only TPA == local_ip.
module arp_decode_stream
    import arp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAC_SIZE   = 48,
    parameter int IP_SIZE    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    arp_decode_stream_if.slave  rx,
    input  logic [IP_SIZE-1:0]  local_ip,
    output logic [15:0]         hardware_type,
    output logic [15:0]         protocol_type,
    output logic [7:0]          hardware_len,
    output logic [7:0]          protocol_len,
    output logic [15:0]         operation,
    output logic [MAC_SIZE-1:0] sender_hardware_address,
    output logic [IP_SIZE-1:0]  sender_protocol_address,
    output logic [MAC_SIZE-1:0] target_hardware_address,
    output logic [IP_SIZE-1:0]  target_protocol_address,
    output logic                decode_valid,
    output logic                decode_error,
    output logic [1:0]          error_code
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int CW  = 6;
    localparam int SW  = ARP_LEN * 8;
    localparam int TOP = SW - 1;

    arp_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  stage_q, stage_d;
    logic [3:0]     nbytes;
    logic           wr_en;
    logic [CW-1:0]  wr_base;
    logic           fin;
    logic           abort;

    assign nbytes = rx.data_in_eop ?
                    4'(NB) - 4'(rx.data_in_empty) : 4'(NB);

    arp_byte_lane_writer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CW         (CW)
    ) u_writer (
        .stage_q (stage_q),
        .data    (rx.data_in),
        .base    (wr_base),
        .nbytes  (nbytes),
        .en      (wr_en),
        .stage_d (stage_d)
    );

    // A sop always restarts at byte 0; outside IDLE it also aborts the
    // frame in flight, and that abort outranks an eop on the same word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_base = cnt_q;
        fin     = 1'b0;
        abort   = 1'b0;
        if (rx.data_in_valid) begin
            if (rx.data_in_sop) begin
                abort   = (state_q != S_IDLE);
                wr_en   = 1'b1;
                wr_base = '0;
                cnt_d   = CW'(nbytes);
            end else if (state_q == S_CAPTURE) begin
                wr_en = 1'b1;
                cnt_d = cnt_q + CW'(nbytes);
            end
            if (rx.data_in_sop || (state_q != S_IDLE)) begin
                if (rx.data_in_eop) begin
                    fin     = !abort;
                    state_d = S_IDLE;
                end else if (cnt_d >= CW'(ARP_LEN)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
        end
    end

    // Checks look at stage_d so the eop word's own bytes are included.
    logic [15:0] f_htype, f_ptype, f_oper;
    logic [7:0]  f_hlen, f_plen;
    logic [47:0] f_sha, f_tha;
    logic [31:0] f_spa, f_tpa;

    assign f_htype = stage_d[TOP-8*OFF_HTYPE -: 16];
    assign f_ptype = stage_d[TOP-8*OFF_PTYPE -: 16];
    assign f_hlen  = stage_d[TOP-8*OFF_HLEN  -: 8];
    assign f_plen  = stage_d[TOP-8*OFF_PLEN  -: 8];
    assign f_oper  = stage_d[TOP-8*OFF_OPER  -: 16];
    assign f_sha   = stage_d[TOP-8*OFF_SHA   -: 48];
    assign f_spa   = stage_d[TOP-8*OFF_SPA   -: 32];
    assign f_tha   = stage_d[TOP-8*OFF_THA   -: 48];
    assign f_tpa   = stage_d[TOP-8*OFF_TPA   -: 32];

    logic short_pkt;
    logic hdr_good;
    logic tgt_ok;
    logic good;
    logic err;
    arp_err_e code;

    assign short_pkt = (cnt_d < CW'(ARP_LEN));
    assign hdr_good  = hdr_ok(f_htype, f_ptype, f_hlen,
                              f_plen, f_oper);

`ifdef ARP_TARGET_FILTER_EN
    assign tgt_ok = (IP_SIZE'(f_tpa) == local_ip);
`else
    logic unused_local_ip;
    assign unused_local_ip = ^local_ip;
    assign tgt_ok = 1'b1;
`endif

    assign good = fin && !short_pkt && hdr_good && tgt_ok;
    assign err  = abort || (fin && !good);

    always_comb begin
        code = ERR_TARGET;
        if (abort)          code = ERR_ABORT;
        else if (short_pkt) code = ERR_SHORT;
        else if (!hdr_good) code = ERR_HEADER;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q                 <= S_IDLE;
            cnt_q                   <= '0;
            stage_q                 <= '0;
            decode_valid            <= 1'b0;
            decode_error            <= 1'b0;
            error_code              <= '0;
            hardware_type           <= '0;
            protocol_type           <= '0;
            hardware_len            <= '0;
            protocol_len            <= '0;
            operation               <= '0;
            sender_hardware_address <= '0;
            sender_protocol_address <= '0;
            target_hardware_address <= '0;
            target_protocol_address <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            decode_valid <= good;
            decode_error <= err;
            error_code   <= err ? code : ERR_SHORT;
            if (good) begin
                hardware_type           <= f_htype;
                protocol_type           <= f_ptype;
                hardware_len            <= f_hlen;
                protocol_len            <= f_plen;
                operation               <= f_oper;
                sender_hardware_address <= MAC_SIZE'(f_sha);
                sender_protocol_address <= IP_SIZE'(f_spa);
                target_hardware_address <= MAC_SIZE'(f_tha);
                target_protocol_address <= IP_SIZE'(f_tpa);
            end
        end
    end
endmodule
